control_sequencer: RTL and testbench

- Hardwired control unit sitting directly upstream of the datapath.
- Generates, one clock per step, the per-cycle bus-drive selects, register load enables, ALU select, memory Read and IncPC strobes for the fetch cycle and for three-register ALU instructions.
- Replaces hand-sequenced control stimulus; its outputs connect straight to the datapath's bus-select vector, reg_enable vector, ALU_Sel, Read and IncPC inputs.
- Consumes IR_data_out.

---
 rtl/cpu_ctrl_pkg.sv | 61 ++++++
 rtl/op_decoder.sv | 40 ++++
 rtl/control_sequencer.sv | 161 ++++++++++++++++
 tb/tb_control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer.
// Contents: FSM state encoding, bus/register bit-map indices, opcode values,
// ALU operation codes, IR field positions and a one-hot select helper.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StHalt = 4'd7
  } state_e;

  // Bit positions shared by bus_sel and reg_enable
  localparam logic [4:0] R0_IDX    = 5'd0;
  localparam logic [4:0] HI_IDX    = 5'd16;
  localparam logic [4:0] LO_IDX    = 5'd17;
  localparam logic [4:0] ZHIGH_IDX = 5'd18;
  localparam logic [4:0] ZLOW_IDX  = 5'd19;
  localparam logic [4:0] PC_IDX    = 5'd20;
  localparam logic [4:0] IR_IDX    = 5'd21;
  localparam logic [4:0] MDR_IDX   = 5'd22;
  localparam logic [4:0] MAR_IDX   = 5'd23;
  localparam logic [4:0] Y_IDX     = 5'd24;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_SHR  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_SHL  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_OR   = 5'd10;
  localparam logic [4:0] OP_HALT = 5'd28;

  localparam logic [4:0] ALU_ADD = 5'd0;
  localparam logic [4:0] ALU_SUB = 5'd1;
  localparam logic [4:0] ALU_AND = 5'd3;
  localparam logic [4:0] ALU_OR  = 5'd4;
  localparam logic [4:0] ALU_SHR = 5'd5;
  localparam logic [4:0] ALU_SHL = 5'd6;
  localparam logic [4:0] ALU_ROR = 5'd8;
  localparam logic [4:0] ALU_ROL = 5'd9;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  function automatic logic [31:0] sel_bit(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decoder.
// Ports:
//   i_op         - 5-bit opcode from IR
//   o_alu_code   - ALU select for ALU opcodes (0 otherwise)
//   o_is_alu     - opcode is a supported three-register ALU instruction
//   o_is_halt    - opcode is HALT
//   o_is_illegal - opcode is neither ALU nor HALT
module op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] i_op,
  output logic [4:0] o_alu_code,
  output logic       o_is_alu,
  output logic       o_is_halt,
  output logic       o_is_illegal
);

  always_comb begin
    o_alu_code = '0;
    o_is_alu   = 1'b1;
    o_is_halt  = 1'b0;
    unique case (i_op)
      OP_ADD:  o_alu_code = ALU_ADD;
      OP_SUB:  o_alu_code = ALU_SUB;
      OP_AND:  o_alu_code = ALU_AND;
      OP_OR:   o_alu_code = ALU_OR;
      OP_SHR:  o_alu_code = ALU_SHR;
      OP_SHL:  o_alu_code = ALU_SHL;
      OP_ROR:  o_alu_code = ALU_ROR;
      OP_ROL:  o_alu_code = ALU_ROL;
      OP_HALT: begin
        o_is_alu  = 1'b0;
        o_is_halt = 1'b1;
      end
      default: o_is_alu = 1'b0;
    endcase
    o_is_illegal = !o_is_alu && !o_is_halt;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) plus three-register ALU
// execute (T3-T5), one state per clock, Moore outputs.
// Ports:
//   i_clock       - system clock, rising edge
//   i_clr_n       - asynchronous active-low clear
//   i_run         - level; permits fetching new instructions
//   i_ir          - IR contents from the datapath
//   o_bus_sel     - one-hot bus driver select
//   o_reg_enable  - register load enables
//   o_alu_sel     - ALU operation select (ALU_IDLE when no op active)
//   o_read        - memory read strobe into MDR
//   o_inc_pc      - PC increment strobe
//   o_state       - present state, for debug
//   o_halted      - high in HALT
//   o_illegal     - sticky unsupported-opcode flag
//   o_instr_count - retired instruction count (wraps)
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0]  ALU_IDLE = 5'd7,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               i_clock,
  input  logic               i_clr_n,
  input  logic               i_run,
  input  logic [31:0]        i_ir,
  output logic [31:0]        o_bus_sel,
  output logic [31:0]        o_reg_enable,
  output logic [4:0]         o_alu_sel,
  output logic               o_read,
  output logic               o_inc_pc,
  output logic [3:0]         o_state,
  output logic               o_halted,
  output logic               o_illegal,
  output logic [COUNT_W-1:0] o_instr_count
);

  state_e             r_state;
  state_e             w_next_state;
  logic               r_illegal;
  logic [COUNT_W-1:0] r_instr_count;

  logic [4:0]  w_op;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;
  logic [4:0]  w_alu_code;
  logic        w_is_alu;
  logic        w_is_halt;
  logic        w_is_illegal;
  logic        w_set_illegal;
  logic [31:0] w_bus_sel;
  logic [31:0] w_reg_en;
  logic [4:0]  w_alu_sel;
  logic        w_read;
  logic        w_inc_pc;
  logic        w_unused_ir;

  assign w_op = i_ir[OP_MSB:OP_LSB];
  assign w_ra = i_ir[RA_MSB:RA_LSB];
  assign w_rb = i_ir[RB_MSB:RB_LSB];
  assign w_rc = i_ir[RC_MSB:RC_LSB];
  assign w_unused_ir = ^i_ir[RC_LSB-1:0];

  op_decoder u_op_decoder (
    .i_op         (w_op),
    .o_alu_code   (w_alu_code),
    .o_is_alu     (w_is_alu),
    .o_is_halt    (w_is_halt),
    .o_is_illegal (w_is_illegal)
  );

  always_ff @(posedge i_clock or negedge i_clr_n) begin
    if (!i_clr_n) begin
      r_state       <= StIdle;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_set_illegal) begin
        r_illegal <= 1'b1;
      end
      // Retire at the end of T5
      if (r_state == StT5) begin
        r_instr_count <= r_instr_count + COUNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_bus_sel     = '0;
    w_reg_en      = '0;
    w_alu_sel     = ALU_IDLE;
    w_read        = 1'b0;
    w_inc_pc      = 1'b0;
    w_set_illegal = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_run) begin
          w_next_state = StT0;
        end
      end
      StT0: begin
        w_bus_sel    = sel_bit(PC_IDX);
        w_reg_en     = sel_bit(MAR_IDX);
        w_inc_pc     = 1'b1;
        w_next_state = StT1;
      end
      StT1: begin
        w_read       = 1'b1;
        w_reg_en     = sel_bit(MDR_IDX);
        w_next_state = StT2;
      end
      StT2: begin
        w_bus_sel    = sel_bit(MDR_IDX);
        w_reg_en     = sel_bit(IR_IDX);
        w_next_state = StT3;
      end
      StT3: begin
        // Going to HALT drives nothing onto the bus
        if (w_is_alu) begin
          w_bus_sel    = sel_bit({1'b0, w_rb});
          w_reg_en     = sel_bit(Y_IDX);
          w_next_state = StT4;
        end else begin
          w_set_illegal = w_is_illegal;
          w_next_state  = StHalt;
        end
      end
      StT4: begin
        w_bus_sel    = sel_bit({1'b0, w_rc});
        w_reg_en     = sel_bit(ZLOW_IDX);
        w_alu_sel    = w_alu_code;
        w_next_state = StT5;
      end
      StT5: begin
        w_bus_sel    = sel_bit(ZLOW_IDX);
        w_reg_en     = sel_bit({1'b0, w_ra});
        w_next_state = i_run ? StT0 : StIdle;
      end
      StHalt: begin
        w_next_state = StHalt;
      end
      default: begin
        w_next_state = StIdle;
      end
    endcase
  end

  assign o_bus_sel     = w_bus_sel;
  assign o_reg_enable  = w_reg_en;
  assign o_alu_sel     = w_alu_sel;
  assign o_read        = w_read;
  assign o_inc_pc      = w_inc_pc;
  assign o_state       = r_state;
  assign o_halted      = (r_state == StHalt);
  assign o_illegal     = r_illegal;
  assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a step-level model checked every
// cycle plus directed scenarios with literal expectations.
module tb_control_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int P_IDLE = 0;
  localparam int P_HALT = 7;  // phases 1..6 are T0..T5

  logic        clk = 1'b0;
  logic        clr_n;
  logic        run;
  logic [31:0] ir;

  logic [31:0] o_bus_sel;
  logic [31:0] o_reg_enable;
  logic [4:0]  o_alu_sel;
  logic        o_read;
  logic        o_inc_pc;
  logic [3:0]  o_state;
  logic        o_halted;
  logic        o_illegal;
  logic [15:0] o_instr_count;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  int          m_phase   = P_IDLE;
  logic        m_illegal = 1'b0;
  logic [15:0] m_count   = '0;

  control_sequencer #(
    .ALU_IDLE (5'd7),
    .COUNT_W  (16)
  ) dut (
    .i_clock       (clk),
    .i_clr_n       (clr_n),
    .i_run         (run),
    .i_ir          (ir),
    .o_bus_sel     (o_bus_sel),
    .o_reg_enable  (o_reg_enable),
    .o_alu_sel     (o_alu_sel),
    .o_read        (o_read),
    .o_inc_pc      (o_inc_pc),
    .o_state       (o_state),
    .o_halted      (o_halted),
    .o_illegal     (o_illegal),
    .o_instr_count (o_instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec opcode table; -1 means not an ALU opcode
  function automatic int alu_of(input int op);
    case (op)
      3: return 0;
      4: return 1;
      9: return 3;
      10: return 4;
      5: return 5;
      7: return 6;
      6: return 8;
      8: return 9;
      default: return -1;
    endcase
  endfunction

  // Model: advance one step per clock, clear immediately on clr
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_phase   = P_IDLE;
      m_illegal = 1'b0;
      m_count   = '0;
    end else begin
      case (m_phase)
        P_IDLE: if (run) m_phase = 1;
        1, 2, 3: m_phase = m_phase + 1;
        4: begin
          if (alu_of(int'(ir[31:27])) >= 0) begin
            m_phase = 5;
          end else begin
            if (int'(ir[31:27]) != 28) m_illegal = 1'b1;
            m_phase = P_HALT;
          end
        end
        5: m_phase = 6;
        6: begin
          m_count = m_count + 16'd1;
          m_phase = run ? 1 : P_IDLE;
        end
        default: m_phase = P_HALT;
      endcase
    end
  end

  // Compare every cycle, on the falling edge
  always @(negedge clk) begin
    logic [31:0] e_bus;
    logic [31:0] e_reg;
    logic [31:0] e_alu;
    logic        e_read;
    logic        e_inc;
    logic [3:0]  e_st;
    int          op;
    if (cmp_en) begin
      e_bus = 0; e_reg = 0; e_alu = 7; e_read = 0; e_inc = 0;
      op = int'(ir[31:27]);
      case (m_phase)
        1: begin e_bus = 32'h0010_0000; e_reg = 32'h0080_0000; e_inc = 1; e_st = StT0; end
        2: begin e_reg = 32'h0040_0000; e_read = 1; e_st = StT1; end
        3: begin e_bus = 32'h0040_0000; e_reg = 32'h0020_0000; e_st = StT2; end
        4: begin
          e_st = StT3;
          if (alu_of(op) >= 0) begin
            e_bus = 32'd1 << ir[22:19];
            e_reg = 32'h0100_0000;
          end
        end
        5: begin
          e_st = StT4;
          e_bus = 32'd1 << ir[18:15];
          e_reg = 32'h0008_0000;
          e_alu = 32'(alu_of(op));
        end
        6: begin e_st = StT5; e_bus = 32'h0008_0000; e_reg = 32'd1 << ir[26:23]; end
        P_HALT: e_st = StHalt;
        default: e_st = StIdle;
      endcase
      check("m_state", 32'(o_state), 32'(e_st));
      check("m_bus_sel", o_bus_sel, e_bus);
      check("m_reg_enable", o_reg_enable, e_reg);
      check("m_alu_sel", 32'(o_alu_sel), e_alu);
      check("m_read", 32'(o_read), 32'(e_read));
      check("m_inc_pc", 32'(o_inc_pc), 32'(e_inc));
      check("m_halted", 32'(o_halted), 32'(m_phase == P_HALT));
      check("m_illegal", 32'(o_illegal), 32'(m_illegal));
      check("m_count", 32'(o_instr_count), 32'(m_count));
      check("bus_onehot", 32'($countones(o_bus_sel) <= 1), 32'd1);
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    clr_n = 1'b0;
    tick(1);
    clr_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 32'(o_state), 32'(StIdle));
    check({tag, "_bus"}, o_bus_sel, 32'h0);
    check({tag, "_reg"}, o_reg_enable, 32'h0);
    check({tag, "_alu"}, 32'(o_alu_sel), 32'd7);
    check({tag, "_rd_inc"}, 32'({o_read, o_inc_pc}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b1;
    run   = 1'b1;
    ir    = 32'h4A92_0000;
    #1 clr_n = 1'b0;
    cmp_en = 1'b1;
    #2;
    // Reset with run held
    check_idle_outputs("rst");
    check("rst_halted", 32'(o_halted), 32'd0);
    check("rst_illegal", 32'(o_illegal), 32'd0);
    check("rst_count", 32'(o_instr_count), 32'd0);
    tick(2);
    check("rst_hold_state", 32'(o_state), 32'(StIdle));
    clr_n = 1'b1;

    // AND R5,R2,R4
    tick(1);
    check("t0_bus", o_bus_sel, 32'h0010_0000);
    check("t0_reg", o_reg_enable, 32'h0080_0000);
    check("t0_inc", 32'(o_inc_pc), 32'd1);
    tick(1);
    check("t1_read", 32'(o_read), 32'd1);
    tick(1);
    check("t2_reg", o_reg_enable, 32'h0020_0000);
    tick(1);
    check("t3_bus", o_bus_sel, 32'h0000_0004);
    check("t3_reg", o_reg_enable, 32'h0100_0000);
    tick(1);
    check("t4_bus", o_bus_sel, 32'h0000_0010);
    check("t4_reg", o_reg_enable, 32'h0008_0000);
    check("t4_alu", 32'(o_alu_sel), 32'd3);
    tick(1);
    check("t5_bus", o_bus_sel, 32'h0008_0000);
    check("t5_reg", o_reg_enable, 32'h0000_0020);
    tick(1);
    check("and_count", 32'(o_instr_count), 32'd1);
    check("and_next_t0", 32'(o_state), 32'(StT0));

    // ADD R3,R2,R4 back to back
    do_reset();
    ir = 32'h1992_0000;
    tick(1);
    check("add_t0", 32'(o_state), 32'(StT0));
    tick(4);
    check("add_t4_alu", 32'(o_alu_sel), 32'd0);
    check("add_t5_reg_pre", o_reg_enable, 32'h0008_0000);
    tick(14);
    check("add_count3", 32'(o_instr_count), 32'd3);
    check("add_back_t0", 32'(o_state), 32'(StT0));

    // Illegal opcode 31
    do_reset();
    ir = 32'hF800_0000;
    tick(4);
    check("ill_t3_state", 32'(o_state), 32'(StT3));
    check("ill_t3_bus", o_bus_sel, 32'h0);
    check("ill_t3_reg", o_reg_enable, 32'h0);
    tick(1);
    check("ill_halt", 32'(o_state), 32'(StHalt));
    check("ill_flag", 32'(o_illegal), 32'd1);
    check("ill_halted", 32'(o_halted), 32'd1);
    run = 1'b0;
    tick(2);
    run = 1'b1;
    tick(2);
    check("ill_still_halt", 32'(o_state), 32'(StHalt));
    check("ill_still_flag", 32'(o_illegal), 32'd1);
    #1 clr_n = 1'b0;
    #1;
    check("ill_clr_flag", 32'(o_illegal), 32'd0);
    check("ill_clr_halted", 32'(o_halted), 32'd0);
    tick(1);
    clr_n = 1'b1;

    // HALT opcode
    ir = 32'hE000_0000;
    tick(5);
    check("halt_state", 32'(o_state), 32'(StHalt));
    check("halt_halted", 32'(o_halted), 32'd1);
    check("halt_no_illegal", 32'(o_illegal), 32'd0);

    // Async clear during T4
    do_reset();
    ir = 32'h4A92_0000;
    tick(5);
    check("aclr_t4_alu", 32'(o_alu_sel), 32'd3);
    #1 clr_n = 1'b0;
    #1;
    check_idle_outputs("aclr");
    tick(1);
    clr_n = 1'b1;

    // run dropped during T2
    tick(3);
    check("rdrop_t2", 32'(o_state), 32'(StT2));
    run = 1'b0;
    tick(3);
    check("rdrop_t5", 32'(o_state), 32'(StT5));
    tick(1);
    check_idle_outputs("rdrop_idle");
    check("rdrop_count", 32'(o_instr_count), 32'd1);
    tick(3);
    check("rdrop_stay_idle", 32'(o_state), 32'(StIdle));
    run = 1'b1;
    tick(1);
    check("rdrop_restart", 32'(o_state), 32'(StT0));
    tick(1);

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
